uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//   8N1 UART transmitter; the transmit-side partner of the UART receiver.
//   Buffers bytes from the core in a synchronous FIFO and serialises each one onto Tx_o.
//   Frame order: start bit (0), 8 data bits LSB first, stop bit (1).
//   Each bit lasts CLKS_PER_BIT clk_i cycles.
//   Sits between the core write port and the board TX pin.
// PARAMETERS
//   CLKS_PER_BIT  16  clk_i cycles per serial bit; must be >= 2
//   DEPTH         16  FIFO entries; must be a power of 2, >= 2
//   DATA_W        8   payload width; fixed at 8 for 8N1
// PORTS
//   clk_i    in   1       single clock; all logic is on the rising edge
//   rst_i    in   1       synchronous, active-high reset
//   d_i      in   DATA_W  byte to transmit
//   wr_i     in   1       write strobe; sampled when high at the clk_i edge
//   full_o   out  1       FIFO holds DEPTH entries
//   empty_o  out  1       FIFO holds 0 entries
//   busy_o   out  1       FSM not in IDLE (frame in progress)
//   ovf_o    out  1       one-cycle pulse: write dropped because the FIFO was full
//   Tx_o     out  1       serial line, registered, idle high
// BEHAVIOUR
//   Reset: Tx_o=1, full_o=0, empty_o=1, busy_o=0, ovf_o=0.
//     FIFO pointers/count=0, state=IDLE, bit and baud counters=0.
//   Reset mid-frame: Tx_o is 1 after the next edge, the FIFO is flushed and the partial frame is discarded.
//   Write handshake:
//     wr_i & ~full_o -> d_i stored at the edge; count+1.
//     wr_i & full_o -> data dropped, count unchanged, ovf_o=1 for 1 cycle.
//     A pop in the same cycle does NOT free a slot for a write made while full.
//     Write & pop in the same cycle with FIFO not full -> count unchanged, both take effect.
//   full_o/empty_o derive from the registered count; they are valid the cycle after the edge that changed it.
//   FSM (enum tx_state_t): IDLE, START, DATA, STOP.
//     IDLE : Tx_o=1. If ~empty_o: pop head into shift reg, baud_cnt=0, go to START.
//     START: Tx_o=0 for CLKS_PER_BIT cycles, then bit_cnt=0, go to DATA.
//     DATA : Tx_o=shift[0] for CLKS_PER_BIT cycles, then shift right and bit_cnt+1.
//            After bit_cnt==7 completes, go to STOP.
//     STOP : Tx_o=1 for CLKS_PER_BIT cycles.
//            At the end, if FIFO non-empty: pop and go straight to START (back-to-back, no idle gap).
//            Otherwise go to IDLE.
//   Baud counter: 0..CLKS_PER_BIT-1; wraps to 0 on each bit boundary.
//     Width is $clog2(CLKS_PER_BIT).
//   Latency: byte accepted at edge E0 into an empty, idle block -> Tx_o falls after edge E1.
//   Frame length is exactly 10*CLKS_PER_BIT cycles.
//   FIFO pointers: $clog2(DEPTH) bits, wrap naturally. Count: $clog2(DEPTH)+1 bits.
//   busy_o=1 from the edge that leaves IDLE until the edge that returns to IDLE.
//   The shift reg holds its value during a frame; d_i changes do not affect the byte in flight.
// STRUCTURE
//   Package uart_pkg: tx_state_t enum, DATA_W=8, START_BIT=1'b0, STOP_BIT=1'b1, IDLE_LVL=1'b1.
//     The same package is shared with the receiver.
//   Sub-module uart_tx_fifo: sync FIFO with ports clk_i, rst_i, wr, rd, din, dout, full, empty.
//     Data output is first-word-fall-through.
//   Top level: FSM + baud counter + bit counter + shift reg + Tx_o register.
// TESTING (CLKS_PER_BIT=16, DEPTH=16 unless noted)
//   1. Write 0xA5 once.
//      -> Tx_o per 16-cycle slot: 0,1,0,1,0,0,1,0,1,1; busy_o high for 160 cycles; empty_o back to 1.
//   2. Write 0x00 then 0xFF on consecutive cycles.
//      -> Two frames; the second start bit begins on the cycle after the first stop bit ends (320 cycles total).
//   3. Write 17 bytes 0x01..0x11 back to back while the line is busy.
//      -> full_o=1 after 16 accepts; 17th write: ovf_o pulses 1 cycle; 0x11 is never transmitted.
//   4. Assert rst_i for 1 cycle during DATA bit 3 with 3 bytes queued.
//      -> Tx_o=1 and empty_o=1 next cycle; no further frames are sent.
//   5. Loopback Tx_o into the UART receiver and send 0x55, 0x3C, 0x80.
//      -> The receiver buffer outputs the same three bytes in order.
//   6. With the FIFO not empty and not full, assert wr_i in the same cycle as the STOP->START pop.
//      -> Count unchanged; byte order is preserved.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: UART types and line levels shared by the transmitter and receiver
package uart_pkg;
  localparam int DATA_W = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;
  localparam logic IDLE_LVL = 1'b1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous first-word-fall-through FIFO buffering bytes for the transmitter
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr,
  input  logic             rd,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic we, re;
  assign full = cnt_q == CW'(DEPTH);
  assign empty = cnt_q == '0;
  assign dout = mem_q[rp_q];
  always_comb begin
    we = wr & ~full;
    re = rd & ~empty;
    wp_d = we ? wp_q + AW'(1) : wp_q;
    rp_d = re ? rp_q + AW'(1) : rp_q;
    cnt_d = cnt_q + CW'(we) - CW'(re);
  end
  always_ff @(posedge clk_i) begin
    if (we) mem_q[wp_q] <= din;
    if (rst_i) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered 8N1 serial transmitter with back-to-back framing
module uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DEPTH = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] d_i,
  input  logic              wr_i,
  output logic              full_o,
  output logic              empty_o,
  output logic              busy_o,
  output logic              ovf_o,
  output logic              Tx_o
);
  import uart_pkg::*;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int NW = $clog2(DATA_W);
  tx_state_t state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [NW-1:0] bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d, head;
  logic tx_q, tx_d, ovf_q, ovf_d, rd, last, full, empty;
  uart_tx_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .wr    (wr_i),
    .rd    (rd),
    .din   (d_i),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );
  always_comb begin
    last = baud_q == BW'(CLKS_PER_BIT - 1);
    rd = ~empty & ((state_q == IDLE) | ((state_q == STOP) & last));
    state_d = (state_q == IDLE) ? (empty ? IDLE : START)
            : ~last ? state_q
            : (state_q == START) ? DATA
            : (state_q == DATA) ? ((bit_q == NW'(DATA_W - 1)) ? STOP : DATA)
            : empty ? IDLE : START;
    baud_d = ((state_q == IDLE) | last) ? '0 : baud_q + BW'(1);
    bit_d = (state_q == START) ? '0 : ((state_q == DATA) & last) ? bit_q + NW'(1) : bit_q;
    shift_d = rd ? head : ((state_q == DATA) & last) ? shift_q >> 1 : shift_q;
    tx_d = (state_d == START) ? START_BIT
         : (state_d == DATA) ? shift_d[0]
         : (state_d == STOP) ? STOP_BIT : IDLE_LVL;
    ovf_d = wr_i & full;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      baud_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      tx_q <= IDLE_LVL;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q <= baud_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      tx_q <= tx_d;
      ovf_q <= ovf_d;
    end
  end
  assign full_o = full;
  assign empty_o = empty;
  assign busy_o = state_q != IDLE;
  assign ovf_o = ovf_q;
  assign Tx_o = tx_q;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench for uart_tx with a loopback receiver model
module tb_uart_tx;
  localparam int CPB = 16;
  localparam int FL = 10 * CPB;
  logic clk, rst_i, wr_i, full_o, empty_o, busy_o, ovf_o, Tx_o;
  logic [7:0] d_i;
  int n_tests = 0;
  int n_fail = 0;
  logic [7:0] rx_q[$];
  logic rx_act = 1'b0;
  int rx_cnt = 0;
  logic [9:0] rx_sh;
  uart_tx #(.CLKS_PER_BIT(CPB), .DEPTH(16), .DATA_W(8)) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .d_i     (d_i),
    .wr_i    (wr_i),
    .full_o  (full_o),
    .empty_o (empty_o),
    .busy_o  (busy_o),
    .ovf_o   (ovf_o),
    .Tx_o    (Tx_o)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (!rx_act) begin
      if (Tx_o == 1'b0 && !rst_i) begin
        rx_act = 1'b1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt % CPB == CPB / 2) begin
        rx_sh[rx_cnt / CPB] = Tx_o;
        if (rx_cnt / CPB == 9) begin
          rx_act = 1'b0;
          if (rx_sh[9] && !rx_sh[0]) rx_q.push_back(rx_sh[8:1]);
        end
      end
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wr_byte(input logic [7:0] b);
    d_i = b;
    wr_i = 1'b1;
    tick();
    wr_i = 1'b0;
  endtask
  task automatic capture(output logic [159:0] line, output logic bz);
    bz = 1'b1;
    for (int i = 0; i < FL; i++) begin
      line[i] = Tx_o;
      bz &= busy_o;
      tick();
    end
  endtask
  task automatic quiet(input int n, output logic ok);
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      ok &= (Tx_o === 1'b1) && (busy_o === 1'b0);
      tick();
    end
  endtask
  function automatic logic [159:0] frame(input logic [7:0] b);
    logic [9:0] f;
    logic [159:0] r;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < FL; i++) r[i] = f[i / CPB];
    return r;
  endfunction
  initial begin
    logic [159:0] line;
    logic bz, ok;
    int rx_base;
    rst_i = 1'b1;
    wr_i = 1'b0;
    d_i = 8'h00;
    tick();
    tick();
    chk("rst_tx", Tx_o, 1);
    chk("rst_full", full_o, 0);
    chk("rst_empty", empty_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_ovf", ovf_o, 0);
    rst_i = 1'b0;
    tick();
    wr_byte(8'hA5);
    chk("t1_empty_after_wr", empty_o, 0);
    chk("t1_tx_still_idle", Tx_o, 1);
    chk("t1_busy_before", busy_o, 0);
    tick();
    chk("t1_tx_fall", Tx_o, 0);
    chk("t1_busy_rise", busy_o, 1);
    capture(line, bz);
    chk("t1_frame_a5", line, frame(8'hA5));
    chk("t1_busy_160", bz, 1);
    chk("t1_busy_end", busy_o, 0);
    chk("t1_empty_end", empty_o, 1);
    chk("t1_tx_end", Tx_o, 1);
    wr_byte(8'h00);
    wr_byte(8'hFF);
    chk("t2_tx_fall", Tx_o, 0);
    capture(line, bz);
    chk("t2_frame_00", line, frame(8'h00));
    capture(line, bz);
    chk("t2_frame_ff", line, frame(8'hFF));
    chk("t2_busy_both", bz, 1);
    chk("t2_busy_end", busy_o, 0);
    chk("t2_empty_end", empty_o, 1);
    wr_byte(8'hEE);
    tick();
    for (int i = 1; i <= 17; i++) begin
      wr_byte(8'(i));
      if (i == 15) chk("t3_full_at15", full_o, 0);
      if (i == 16) begin
        chk("t3_full_at16", full_o, 1);
        chk("t3_ovf_at16", ovf_o, 0);
      end
      if (i == 17) begin
        chk("t3_ovf_pulse", ovf_o, 1);
        chk("t3_full_at17", full_o, 1);
      end
    end
    tick();
    chk("t3_ovf_drop", ovf_o, 0);
    repeat (FL - 18) tick();
    for (int j = 1; j <= 16; j++) begin
      capture(line, bz);
      chk($sformatf("t3_frame_%0d", j), line, frame(8'(j)));
    end
    chk("t3_busy_end", busy_o, 0);
    chk("t3_empty_end", empty_o, 1);
    quiet(40, ok);
    chk("t3_no_0x11", ok, 1);
    wr_byte(8'h52);
    wr_byte(8'h11);
    wr_byte(8'h22);
    wr_byte(8'h33);
    repeat (67) tick();
    chk("t4_data_bit3", Tx_o, 0);
    chk("t4_busy_mid", busy_o, 1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("t4_tx_rst", Tx_o, 1);
    chk("t4_empty_rst", empty_o, 1);
    chk("t4_busy_rst", busy_o, 0);
    quiet(400, ok);
    chk("t4_no_frames", ok, 1);
    rx_base = rx_q.size();
    wr_byte(8'h55);
    wr_byte(8'h3C);
    wr_byte(8'h80);
    repeat (3 * FL + 40) tick();
    chk("t5_rx_count", rx_q.size() - rx_base, 3);
    if (rx_q.size() - rx_base >= 3) begin
      chk("t5_rx_0", rx_q[rx_base], 8'h55);
      chk("t5_rx_1", rx_q[rx_base + 1], 8'h3C);
      chk("t5_rx_2", rx_q[rx_base + 2], 8'h80);
    end
    wr_byte(8'hC3);
    wr_byte(8'h96);
    repeat (FL - 1) tick();
    d_i = 8'h69;
    wr_i = 1'b1;
    tick();
    wr_i = 1'b0;
    chk("t6_count_kept", empty_o, 0);
    chk("t6_tx_start", Tx_o, 0);
    capture(line, bz);
    chk("t6_frame_96", line, frame(8'h96));
    capture(line, bz);
    chk("t6_frame_69", line, frame(8'h69));
    chk("t6_busy_end", busy_o, 0);
    chk("t6_empty_end", empty_o, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
